// File: rtl/altmem_reader.sv
// rtl/altmem_reader.sv - RAM read front end with a 3-deep response FIFO and write forwarding
//
// Accepts one read request per cycle, issues it to the RAM read port and
// queues the result one cycle later. A write to the same address in the
// accepting cycle is forwarded, because the RAM's mixed-port
// read-during-write result is undefined.
module altmem_reader #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  MEM_REN,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRR,
  input  logic [DATA_WIDTH-1:0] MEM_DO,
  input  logic                  WR_EN,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA
);

  logic [1:0]            cnt;
  logic                  inf;
  logic                  fwd;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH-1:0] fifo [0:2];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;

  logic [2:0]            occupancy;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Handshake and RAM read port; readiness counts the in-flight read as a reserved slot
  always_comb begin
    occupancy = {1'b0, cnt} + {2'b00, inf};
    REQ_READY = !RST && (occupancy < 3'd3);
    accept    = REQ_VALID && REQ_READY;
    MEM_REN   = accept;
    MEM_ADDRR = REQ_ADDR;
    push      = inf;
    push_data = fwd ? fwd_data : MEM_DO;
    RSP_VALID = !RST && (cnt != 2'd0);
    RSP_DATA  = fifo[rd_ptr];
    pop       = RSP_VALID && RSP_READY;
  end

  // Control state: in-flight flag, forward capture, pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= 2'd0;
      inf    <= 1'b0;
      fwd    <= 1'b0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
    end else begin
      inf      <= accept;
      fwd      <= accept && WR_EN && (WR_ADDR == REQ_ADDR);
      fwd_data <= WR_DATA;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge CLK) begin
    if (!RST && push) fifo[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_altmem_reader.sv
// tb/tb_altmem_reader.sv - directed bench for altmem_reader with a behavioural RAM
module tb_altmem_reader;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [AW-1:0] REQ_ADDR;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [DW-1:0] RSP_DATA;
  logic          MEM_REN;
  logic [AW-1:0] MEM_ADDRR;
  logic [DW-1:0] MEM_DO;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:15];

  altmem_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .MEM_REN(MEM_REN), .MEM_ADDRR(MEM_ADDRR), .MEM_DO(MEM_DO),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
  );

  always #5 CLK = ~CLK;

  // RAM: one-cycle read; a read colliding with a write returns junk 0xEE
  always @(posedge CLK) begin
    if (MEM_REN) MEM_DO <= (WR_EN && WR_ADDR == MEM_ADDRR) ? 8'hEE : mem[MEM_ADDRR];
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_VALID = 1'b1; REQ_ADDR = 4'd3; RSP_READY = 1'b1;
    tick(); tick();
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", REQ_READY); end
    checks++; if (MEM_REN !== 1'b0) begin errors++; $display("FAIL reset_mem_ren: got %b expected 0", MEM_REN); end
    checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", RSP_VALID); end
    @(posedge CLK); #1;
    RST = 1'b0; REQ_VALID = 1'b0;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b expected 1", REQ_READY); end
    checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL post_reset_rsp_valid: got %b expected 0", RSP_VALID); end
    @(posedge CLK); #1;
  endtask

  task automatic test_single_read();
    mem_write(4'd5, 8'hAB);
    RSP_READY = 1'b1; REQ_VALID = 1'b1; REQ_ADDR = 4'd5;
    @(negedge CLK);
    checks++; if (MEM_REN !== 1'b1) begin errors++; $display("FAIL single_mem_ren: got %b expected 1", MEM_REN); end
    checks++; if (MEM_ADDRR !== 4'd5) begin errors++; $display("FAIL single_mem_addr: got %0d expected 5", MEM_ADDRR); end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %b expected 0", RSP_VALID); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b1) begin errors++; $display("FAIL single_t2_valid: got %b expected 1", RSP_VALID); end
    checks++; if (RSP_DATA !== 8'hAB) begin errors++; $display("FAIL single_t2_data: got %h expected ab", RSP_DATA); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL single_t3_valid: got %b expected 0", RSP_VALID); end
    @(posedge CLK); #1;
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp;
    for (int i = 0; i < 8; i++) mem_write(AW'(i), DW'(8'h30 + i));
    RSP_READY = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      REQ_VALID = (c < 8);
      REQ_ADDR  = AW'(c);
      @(negedge CLK);
      if (c < 8) begin
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL stream_ready c=%0d: got %b expected 1", c, REQ_READY); end
      end
      if (c >= 2 && c < 10) begin
        exp = DW'(8'h30 + c - 2);
        checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== exp) begin
          errors++; $display("FAIL stream_rsp c=%0d: got valid=%b data=%h expected valid=1 data=%h", c, RSP_VALID, RSP_DATA, exp);
        end
      end
      if (c == 10) begin
        checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b expected 0", RSP_VALID); end
      end
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got [$];
    int next_addr;
    logic acc;
    next_addr = 0;
    for (int c = 0; c < 25; c++) begin
      REQ_VALID = (next_addr < 6);
      REQ_ADDR  = AW'(next_addr);
      RSP_READY = (c >= 6);
      @(negedge CLK);
      if (c < 6) begin
        checks++; if (REQ_READY !== (c < 3)) begin errors++; $display("FAIL bp_ready c=%0d: got %b expected %b", c, REQ_READY, (c < 3)); end
      end
      if (c == 5) begin
        checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 8'h30) begin
          errors++; $display("FAIL bp_head_held: got valid=%b data=%h expected valid=1 data=30", RSP_VALID, RSP_DATA);
        end
      end
      if (c == 7) begin
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b expected 1", REQ_READY); end
      end
      acc = REQ_VALID && REQ_READY;
      if (RSP_VALID && RSP_READY) got.push_back(RSP_DATA);
      @(posedge CLK); #1;
      if (acc) next_addr++;
    end
    REQ_VALID = 1'b0;
    checks++; if (got.size() != 6) begin errors++; $display("FAIL bp_count: got %0d responses expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++; if (got[i] !== DW'(8'h30 + i)) begin errors++; $display("FAIL bp_order i=%0d: got %h expected %h", i, got[i], DW'(8'h30 + i)); end
    end
  endtask

  task automatic test_hazard();
    RSP_READY = 1'b1;
    mem_write(4'd9, 8'h11);
    REQ_VALID = 1'b1; REQ_ADDR = 4'd9;
    WR_EN = 1'b1; WR_ADDR = 4'd9; WR_DATA = 8'h5A;
    tick();
    REQ_VALID = 1'b0; WR_EN = 1'b0;
    tick();
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 8'h5A) begin
      errors++; $display("FAIL hazard_same_cycle: got valid=%b data=%h expected valid=1 data=5a", RSP_VALID, RSP_DATA);
    end
    @(posedge CLK); #1;
    mem_write(4'd9, 8'h11);
    REQ_VALID = 1'b1; REQ_ADDR = 4'd9;
    tick();
    REQ_VALID = 1'b0;
    WR_EN = 1'b1; WR_ADDR = 4'd9; WR_DATA = 8'h5A;
    tick();
    WR_EN = 1'b0;
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 8'h11) begin
      errors++; $display("FAIL hazard_later_write: got valid=%b data=%h expected valid=1 data=11", RSP_VALID, RSP_DATA);
    end
    @(posedge CLK); #1;
    mem_write(4'd9, 8'h77);
    REQ_VALID = 1'b1; REQ_ADDR = 4'd9;
    tick();
    REQ_VALID = 1'b0;
    tick();
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 8'h77) begin
      errors++; $display("FAIL hazard_earlier_write: got valid=%b data=%h expected valid=1 data=77", RSP_VALID, RSP_DATA);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_midop();
    int stale;
    RSP_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      REQ_VALID = 1'b1; REQ_ADDR = AW'(c);
      tick();
    end
    RST = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL midop_rsp_valid c=%0d: got %b expected 0", c, RSP_VALID); end
      checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL midop_req_ready c=%0d: got %b expected 0", c, REQ_READY); end
      checks++; if (MEM_REN !== 1'b0) begin errors++; $display("FAIL midop_mem_ren c=%0d: got %b expected 0", c, MEM_REN); end
      @(posedge CLK); #1;
    end
    RST = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b1;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL midop_release_ready: got %b expected 1", REQ_READY); end
    @(posedge CLK); #1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (RSP_VALID !== 1'b0) stale++;
      @(posedge CLK); #1;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midop_stale: got %0d stale cycles expected 0", stale); end
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; RSP_READY = 1'b0;
    WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    tick();
    test_reset();
    test_single_read();
    test_streaming();
    test_backpressure();
    test_hazard();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/altmem_reader.md
ALTMEM_READER -- requirements
Module: altmem_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 1, width of the read and write addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 1, width of the read and write data.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port REQ_VALID  input  1  read request present.
REQ-006 SHALL have port REQ_READY  output  1  request accepted this cycle when high with REQ_VALID.
REQ-007 SHALL have port REQ_ADDR  input  ADDR_WIDTH  read address.
REQ-008 SHALL have port RSP_VALID  output  1  response data present.
REQ-009 SHALL have port RSP_READY  input  1  consumer takes the response.
REQ-010 SHALL have port RSP_DATA  output  DATA_WIDTH  response data.
REQ-011 SHALL have port MEM_REN  output  1  read enable to the dual-port RAM read port.
REQ-012 SHALL have port MEM_ADDRR  output  ADDR_WIDTH  read address to the RAM.
REQ-013 SHALL have port MEM_DO  input  DATA_WIDTH  RAM read data, valid on the cycle after MEM_REN.
REQ-014 SHALL have port WR_EN  input  1  snoop of the RAM write enable.
REQ-015 SHALL have port WR_ADDR  input  ADDR_WIDTH  snoop of the RAM write address.
REQ-016 SHALL have port WR_DATA  input  DATA_WIDTH  snoop of the RAM write data.

Function
REQ-017 SHALL hold a 3-entry in-order response FIFO with occupancy count CNT in the range 0..3, and a one-bit in-flight flag INF.
REQ-018 SHALL drive REQ_READY = !RST && (CNT + INF < 3), derived from registers only, with no path from RSP_READY.
REQ-019 SHALL drive MEM_REN = REQ_VALID && REQ_READY and MEM_ADDRR = REQ_ADDR, combinationally.
REQ-020 SHALL set INF to 1 on the edge after an accepted request, and clear it to 0 otherwise.
REQ-021 SHALL push one entry into the FIFO on each cycle with INF=1, capturing MEM_DO, or the forwarded data when flagged.
REQ-022 SHALL register FWD=1 and FWD_DATA=WR_DATA on acceptance when WR_EN && WR_ADDR==REQ_ADDR in the same cycle, because the RAM mixed-port read-during-write result is undefined.
REQ-023 SHALL forward only a write that coincides with the accepting cycle; earlier writes are read from the RAM and later writes do not affect the response.
REQ-024 SHALL drive RSP_VALID = (CNT != 0), with RSP_DATA equal to the head entry.
REQ-025 SHALL pop the head entry on RSP_VALID && RSP_READY.
REQ-026 SHALL apply a simultaneous push and pop as CNT unchanged with order preserved, including when CNT=3.
REQ-027 SHALL sustain one request per cycle when RSP_READY is held high, with response latency of 2 cycles from acceptance to RSP_VALID.
REQ-028 SHALL ignore REQ_ADDR and the WR_* inputs while no request is accepted.

Reset
REQ-029 SHALL, with RST high, on the next edge set CNT=0, INF=0 and FWD=0 and clear the FIFO pointers.
REQ-030 SHALL, while RST is high, hold REQ_READY=0, MEM_REN=0 and RSP_VALID=0.
REQ-031 SHALL discard an in-flight read on reset mid-operation, so that no response is produced for it after reset.

Verification
REQ-032 SHALL pass single read: mem[5]=0xAB, request addr 5 at t0 -> MEM_REN=1 at t0, RSP_VALID=1 with RSP_DATA=0xAB at t2.
REQ-033 SHALL pass streaming: addrs 0..7 on back-to-back cycles with RSP_READY=1 -> 8 responses in order on consecutive cycles, REQ_READY never low.
REQ-034 SHALL pass backpressure: RSP_READY=0 with continuous requests -> REQ_READY falls after 3 acceptances; RSP_READY=1 -> the 3 responses in order, then resume, no loss or duplication.
REQ-035 SHALL pass hazard: read addr 9 and write addr 9 data 0x5A in the same cycle, old mem[9]=0x11 -> response 0x5A; write one cycle later -> response 0x11.
REQ-036 SHALL pass reset mid-op: RST at the cycle after acceptance with CNT=2 -> RSP_VALID=0 and REQ_READY=0 during RST, no stale response after release.
